screen_monitor: RTL and testbench
=================================

SCREEN_MONITOR -- requirements
Module: screen_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on every panel input (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; sole clock of the block.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rclk  input  1  row shift clock from the panel driver.
REQ-005 SHALL have port rsdi  input  1  row serial data.
REQ-006 SHALL have port cclk  input  1  column shift clock.
REQ-007 SHALL have port csdi  input  1  column serial data.
REQ-008 SHALL have port le  input  1  latch enable.
REQ-009 SHALL have port oeb  input  1  output enable, active-low.
REQ-010 SHALL have port rd_row  input  4  framebuffer read row index.
REQ-011 SHALL have port rd_data  output  16  registered column pattern of row rd_row.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when row 15 commits.
REQ-013 SHALL have port proto_err  output  1  one-cycle pulse on a malformed scan.
REQ-014 SHALL have port frame_count  output  8  committed-frame counter.

Function
REQ-015 All panel inputs SHALL pass through a SYNC_STAGES flop chain; edges SHALL be detected on synchronized values only.
REQ-016 On a synchronized rclk rising edge, row_sr SHALL shift left with rsdi entering bit 0; cclk/csdi/col_sr likewise.
REQ-017 Each shift register SHALL have a 5-bit bit counter, incremented per shift, saturating at 31, cleared on le rising edge.
REQ-018 On a synchronized le rising edge, row_sr and col_sr SHALL copy to row_lat and col_lat, and pending SHALL be set.
REQ-019 If a shift edge and an le edge are detected in the same cycle, the shift SHALL apply first and the latched value SHALL include the new bit.
REQ-020 On le rising edge, if either bit counter is not 16, proto_err SHALL pulse the following cycle and pending SHALL remain clear.
REQ-021 While pending is set and synchronized oeb is 0, the block SHALL commit in one cycle and clear pending.
REQ-022 Commit: if row_lat is one-hot with bit r set, fb[r] SHALL be loaded with col_lat; otherwise proto_err SHALL pulse and fb SHALL not change.
REQ-023 A commit to r=15 SHALL pulse frame_done the next cycle and increment frame_count, wrapping 255 to 0.
REQ-024 A new le edge while pending is set SHALL overwrite row_lat and col_lat; only the latest scan commits.
REQ-025 rd_data SHALL equal fb[rd_row] one cycle after rd_row is applied; a same-cycle commit to that row SHALL be visible one cycle later.
REQ-026 Latency from the raw le edge to the fb update (oeb already low) SHALL be SYNC_STAGES+2 cycles.

Reset
REQ-027 Reset SHALL clear synchronizers, row_sr, col_sr, both latches, bit counters, pending, all 16 fb rows, rd_data, frame_done, proto_err and frame_count to 0.
REQ-028 Reset asserted mid-shift or with pending set SHALL discard the partial scan; capture SHALL resume with the first edge after reset deasserts.

Structure
REQ-029 A shared package SHALL hold ROWS=16, COLS=16, the bit-counter width (5) and the fb row type.
REQ-030 One sub-module, edge_sync (SYNC_STAGES synchronizer plus rise/fall detector), SHALL be instantiated per input clock/strobe; data inputs SHALL use the synchronizer only.

Verification
REQ-031 Shift row 0x0004 and cols 0xA5A5 at 16 bits each, pulse le, oeb low -> fb[2]=0xA5A5; rd_row=2 gives rd_data=0xA5A5; no proto_err.
REQ-032 Scan rows 0..15 in order with cols=row index -> frame_done pulses once after row 15; frame_count=1; fb[k]=k.
REQ-033 Shift 15 row bits, then le -> proto_err pulses once; fb unchanged.
REQ-034 Shift row 0x0011 (two bits set) -> proto_err at commit; fb unchanged.
REQ-035 Two le edges with oeb held high, then oeb low -> only the second scan commits.
REQ-036 Assert reset with pending set -> all fb rows 0, frame_count=0; a following valid scan commits normally.

Source files
------------

// File: rtl/screen_monitor_pkg.sv
// Shared geometry, bit-counter sizing and framebuffer row type for the screen monitor.
package screen_monitor_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int BCNT_W = 5;

    localparam logic [BCNT_W-1:0] BCNT_MAX  = 5'd31;
    localparam logic [BCNT_W-1:0] SCAN_BITS = 5'd16;

    typedef logic [COLS-1:0] fb_row_t;
    typedef logic [ROWS-1:0] row_sel_t;

    function automatic logic is_onehot(input row_sel_t sel);
        return (sel != '0) && ((sel & (sel - row_sel_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a single-cycle edge detector (rise or fall).
module edge_sync #(
    parameter int STAGES      = 2,
    parameter bit DETECT_RISE = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic pulse
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;
    logic              sync_val;

    assign sync_val = chain_reg[STAGES-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            chain_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
            prev_reg  <= sync_val;
        end
    end

    // Combinational from the synchronized value so the edge acts one cycle after it settles.
    assign pulse = DETECT_RISE ? (sync_val & ~prev_reg) : (~sync_val & prev_reg);

endmodule

// File: rtl/screen_monitor.sv
// Snoops a serial row/column LED panel bus, rebuilds the displayed image in a
// 16x16 framebuffer and flags malformed scans.
module screen_monitor
    import screen_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rclk,
    input  logic        rsdi,
    input  logic        cclk,
    input  logic        csdi,
    input  logic        le,
    input  logic        oeb,
    input  logic [3:0]  rd_row,
    output logic [15:0] rd_data,
    output logic        frame_done,
    output logic        proto_err,
    output logic [7:0]  frame_count
);

    localparam int N_DATA = 3;

    logic rclk_rise, cclk_rise, le_rise;

    edge_sync #(.STAGES(SYNC_STAGES)) u_rclk_sync (.clk(clk), .srst(reset), .d(rclk), .pulse(rclk_rise));
    edge_sync #(.STAGES(SYNC_STAGES)) u_cclk_sync (.clk(clk), .srst(reset), .d(cclk), .pulse(cclk_rise));
    edge_sync #(.STAGES(SYNC_STAGES)) u_le_sync   (.clk(clk), .srst(reset), .d(le),   .pulse(le_rise));

    // Data lines share the clock-line depth so each bit lines up with its shift edge.
    logic [N_DATA-1:0]      data_raw;
    logic [N_DATA-1:0]      data_sync;
    logic [SYNC_STAGES-1:0] data_chain_reg [N_DATA];

    assign data_raw = {oeb, csdi, rsdi};

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_DATA; i++) begin
            if (reset) data_chain_reg[i] <= '0;
            else       data_chain_reg[i] <= {data_chain_reg[i][SYNC_STAGES-2:0], data_raw[i]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DATA; gi++) begin : g_data_sync
            assign data_sync[gi] = data_chain_reg[gi][SYNC_STAGES-1];
        end
    endgenerate

    logic rsdi_s, csdi_s, oeb_s;
    assign rsdi_s = data_sync[0];
    assign csdi_s = data_sync[1];
    assign oeb_s  = data_sync[2];

    row_sel_t          row_sr_reg, row_sr_next, row_lat_reg;
    fb_row_t           col_sr_reg, col_sr_next, col_lat_reg;
    logic [BCNT_W-1:0] row_cnt_reg, row_cnt_next, col_cnt_reg, col_cnt_next;
    logic              pending_reg;
    logic              scan_ok, commit, commit_ok, frame_hit;
    row_sel_t          row_we;
    fb_row_t           fb_reg [ROWS];
    fb_row_t           rd_data_reg;
    logic              frame_done_reg, proto_err_reg;
    logic [7:0]        frame_count_reg;

    always_comb begin
        row_sr_next  = row_sr_reg;
        col_sr_next  = col_sr_reg;
        row_cnt_next = row_cnt_reg;
        col_cnt_next = col_cnt_reg;
        if (rclk_rise) begin
            row_sr_next = {row_sr_reg[ROWS-2:0], rsdi_s};
            if (row_cnt_reg != BCNT_MAX) row_cnt_next = row_cnt_reg + 1'b1;
        end
        if (cclk_rise) begin
            col_sr_next = {col_sr_reg[COLS-2:0], csdi_s};
            if (col_cnt_reg != BCNT_MAX) col_cnt_next = col_cnt_reg + 1'b1;
        end
    end

    // Count check includes a bit shifted in on the same cycle as the latch edge.
    assign scan_ok   = (row_cnt_next == SCAN_BITS) && (col_cnt_next == SCAN_BITS);
    assign commit    = pending_reg & ~oeb_s;
    assign commit_ok = commit & is_onehot(row_lat_reg);
    assign row_we    = commit_ok ? row_lat_reg : '0;
    assign frame_hit = row_we[ROWS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            row_sr_reg      <= '0;
            col_sr_reg      <= '0;
            row_cnt_reg     <= '0;
            col_cnt_reg     <= '0;
            row_lat_reg     <= '0;
            col_lat_reg     <= '0;
            pending_reg     <= 1'b0;
            proto_err_reg   <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            row_sr_reg     <= row_sr_next;
            col_sr_reg     <= col_sr_next;
            row_cnt_reg    <= le_rise ? '0 : row_cnt_next;
            col_cnt_reg    <= le_rise ? '0 : col_cnt_next;
            proto_err_reg  <= (le_rise & ~scan_ok) | (commit & ~commit_ok);
            frame_done_reg <= frame_hit;
            if (frame_hit) frame_count_reg <= frame_count_reg + 1'b1;
            if (le_rise) begin
                row_lat_reg <= row_sr_next;
                col_lat_reg <= col_sr_next;
                pending_reg <= scan_ok;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (reset)          fb_reg[r] <= '0;
            else if (row_we[r]) fb_reg[r] <= col_lat_reg;
        end
        if (reset) rd_data_reg <= '0;
        else       rd_data_reg <= fb_reg[rd_row];
    end

    assign rd_data     = rd_data_reg;
    assign frame_done  = frame_done_reg;
    assign proto_err   = proto_err_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_screen_monitor.sv
// Directed checks of the screen monitor: scan capture, framing, error cases and reset.
module tb_screen_monitor;

    logic        clk = 1'b0;
    logic        reset, rclk, rsdi, cclk, csdi, le, oeb;
    logic [3:0]  rd_row;
    logic [15:0] rd_data;
    logic        frame_done, proto_err;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int perr_cnt = 0;
    int fd_cnt   = 0;

    always #5 clk = ~clk;

    screen_monitor #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi),
        .le(le), .oeb(oeb), .rd_row(rd_row), .rd_data(rd_data),
        .frame_done(frame_done), .proto_err(proto_err), .frame_count(frame_count)
    );

    always @(posedge clk) begin
        #1;
        if (proto_err)  perr_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends 16 column bits and the low nrow row bits, MSB first.
    task automatic shift_scan(input logic [15:0] row, input logic [15:0] col, input int nrow);
        for (int i = 15; i >= 0; i--) begin
            rsdi = row[i];
            csdi = col[i];
            tick(3);
            rclk = (i < nrow);
            cclk = 1'b1;
            tick(3);
            rclk = 1'b0;
            cclk = 1'b0;
            tick(2);
        end
    endtask

    task automatic pulse_le();
        le = 1'b1;
        tick(4);
        le = 1'b0;
        tick(6);
    endtask

    task automatic read_row(input logic [3:0] r, output logic [15:0] val);
        rd_row = r;
        tick(1);
        val = rd_data;
    endtask

    initial begin
        logic [15:0] v;
        int perr_base, fd_base;

        reset = 1'b1; rclk = 0; rsdi = 0; cclk = 0; csdi = 0; le = 0; oeb = 1'b1; rd_row = 4'd0;
        tick(4);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_frame_count", 32'(frame_count), 32'h0);
        check("reset_pulses", 32'({frame_done, proto_err}), 32'h0);
        reset = 1'b0;
        oeb = 1'b0;
        tick(2);

        // Single valid scan plus latency from raw le edge to readback.
        perr_base = perr_cnt;
        shift_scan(16'h0004, 16'hA5A5, 16);
        rd_row = 4'd2;
        tick(1);
        le = 1'b1;
        tick(4);
        check("latency_before_commit", 32'(rd_data), 32'h0);
        tick(1);
        check("row2_a5a5", 32'(rd_data), 32'hA5A5);
        le = 1'b0;
        tick(6);
        check("scan1_no_perr", 32'(perr_cnt - perr_base), 32'd0);

        // Full frame, column pattern equals row index.
        perr_base = perr_cnt;
        fd_base   = fd_cnt;
        for (int k = 0; k < 16; k++) begin
            shift_scan(16'(1 << k), 16'(k), 16);
            pulse_le();
        end
        check("frame_done_once", 32'(fd_cnt - fd_base), 32'd1);
        check("frame_count_1", 32'(frame_count), 32'd1);
        check("frame_no_perr", 32'(perr_cnt - perr_base), 32'd0);
        read_row(4'd0, v);  check("fb0", 32'(v), 32'd0);
        read_row(4'd5, v);  check("fb5", 32'(v), 32'd5);
        read_row(4'd15, v); check("fb15", 32'(v), 32'd15);

        // Short row scan is rejected at the latch edge.
        perr_base = perr_cnt;
        shift_scan(16'h0004, 16'h3C3C, 15);
        pulse_le();
        tick(4);
        check("short_scan_perr", 32'(perr_cnt - perr_base), 32'd1);
        read_row(4'd2, v); check("short_scan_fb2", 32'(v), 32'd2);

        // Two row bits set is rejected at commit.
        perr_base = perr_cnt;
        shift_scan(16'h0011, 16'hFFFF, 16);
        pulse_le();
        tick(4);
        check("twohot_perr", 32'(perr_cnt - perr_base), 32'd1);
        read_row(4'd0, v); check("twohot_fb0", 32'(v), 32'd0);
        read_row(4'd4, v); check("twohot_fb4", 32'(v), 32'd4);

        // With oeb high, a second latch overwrites the first.
        oeb = 1'b1;
        shift_scan(16'h0040, 16'h1111, 16);
        pulse_le();
        shift_scan(16'h0008, 16'h2222, 16);
        pulse_le();
        read_row(4'd3, v); check("held_fb3_old", 32'(v), 32'd3);
        oeb = 1'b0;
        tick(8);
        read_row(4'd3, v); check("overwrite_fb3", 32'(v), 32'h2222);
        read_row(4'd6, v); check("overwrite_fb6", 32'(v), 32'd6);

        // Reset with a scan pending discards it and clears everything.
        oeb = 1'b1;
        shift_scan(16'h0080, 16'hBEEF, 16);
        pulse_le();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("post_reset_frame_count", 32'(frame_count), 32'd0);
        oeb = 1'b0;
        tick(8);
        for (int r = 0; r < 16; r++) begin
            read_row(4'(r), v);
            check($sformatf("post_reset_fb%0d", r), 32'(v), 32'd0);
        end
        shift_scan(16'h0080, 16'h7777, 16);
        pulse_le();
        read_row(4'd7, v); check("post_reset_scan_fb7", 32'(v), 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
